// File: rtl/main_counter.sv
// main_counter: shared PWM/timer time-base counter on the divided slow clock.
// Ports: slow_clk, rst (async, active-low), sw_rst, irq_rst, counter_en,
//   mode (1=PWM, 0=timer), timer_mode (1=continuous, 0=one-shot),
//   period_reg, counter (registered count), wrap (optional; when
//   MAIN_COUNTER_WRAP_PULSE_EN is defined, a one-cycle pulse on each wrap to 0).
module main_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             slow_clk,
  input  logic             rst,
  input  logic             sw_rst,
  input  logic             irq_rst,
  input  logic             counter_en,
  input  logic             mode,
  input  logic             timer_mode,
  input  logic [WIDTH-1:0] period_reg,
  output logic [WIDTH-1:0] counter
`ifdef MAIN_COUNTER_WRAP_PULSE_EN
  ,
  output logic             wrap
`endif
);

  logic [WIDTH-1:0] counter_q, counter_d;
  logic             armed_q, armed_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] cnt_inc;
  logic [WIDTH:0]   cnt_inc_x;
  logic             pwm_hit;
  logic             tmr_hit;

  assign cnt_inc   = counter_q + 1'b1;
  assign cnt_inc_x = {1'b0, counter_q} + 1'b1;

  // Extended compare: counter+1 >= P is counter >= P-1 without the
  // P=0 underflow, so P=0 pins the count at 0.
  assign pwm_hit = (cnt_inc_x >= {1'b0, period_reg});
  assign tmr_hit = (counter_q >= period_reg);

  always_comb begin
    counter_d = counter_q;
    armed_d   = armed_q;
    done_d    = done_q;
    if (sw_rst) begin
      counter_d = '0;
      armed_d   = 1'b0;
      done_d    = 1'b0;
    end else if (!counter_en) begin
      counter_d = counter_q;
    end else if (mode) begin
      armed_d   = 1'b0;
      done_d    = 1'b0;
      counter_d = pwm_hit ? '0 : cnt_inc;
    end else if (irq_rst) begin
      counter_d = '0;
      armed_d   = 1'b0;
      done_d    = 1'b0;
    end else if (!armed_q) begin
      // Start-latency tick: arm only, count does not move.
      armed_d = 1'b1;
    end else if (done_q) begin
      counter_d = '0;
    end else if (tmr_hit) begin
      counter_d = '0;
      done_d    = !timer_mode;
    end else begin
      counter_d = cnt_inc;
    end
  end

  always_ff @(posedge slow_clk or negedge rst) begin
    if (!rst) begin
      counter_q <= '0;
      armed_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      counter_q <= counter_d;
      armed_q   <= armed_d;
      done_q    <= done_d;
    end
  end

  assign counter = counter_q;

`ifdef MAIN_COUNTER_WRAP_PULSE_EN
  logic wrap_q, wrap_d;

  always_comb begin
    wrap_d = 1'b0;
    if (!sw_rst && counter_en) begin
      if (mode)
        wrap_d = pwm_hit;
      else
        wrap_d = !irq_rst && armed_q && !done_q && tmr_hit;
    end
  end

  always_ff @(posedge slow_clk or negedge rst) begin
    if (!rst)
      wrap_q <= 1'b0;
    else
      wrap_q <= wrap_d;
  end

  assign wrap = wrap_q;
`endif

endmodule

// File: tb/tb_main_counter.sv
// tb_main_counter: directed scoreboard bench for main_counter.
// Expected counts are queued per step and popped after each slow_clk edge.
module tb_main_counter;

  logic        slow_clk;
  logic        rst;
  logic        sw_rst;
  logic        irq_rst;
  logic        counter_en;
  logic        mode;
  logic        timer_mode;
  logic [15:0] period_reg;
  logic [15:0] counter;
`ifdef MAIN_COUNTER_WRAP_PULSE_EN
  logic        wrap;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] exp_q[$];

  main_counter #(.WIDTH(16)) dut (
    .slow_clk   (slow_clk),
    .rst        (rst),
    .sw_rst     (sw_rst),
    .irq_rst    (irq_rst),
    .counter_en (counter_en),
    .mode       (mode),
    .timer_mode (timer_mode),
    .period_reg (period_reg),
    .counter    (counter)
`ifdef MAIN_COUNTER_WRAP_PULSE_EN
    ,
    .wrap       (wrap)
`endif
  );

  initial slow_clk = 1'b0;
  always #5 slow_clk = ~slow_clk;

  task automatic check_now(input string tag);
    logic [15:0] e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL %s scoreboard empty", tag);
    end else begin
      e = exp_q.pop_front();
      n_cmp++;
      assert (counter === e) else begin
        n_bad++;
        $error("FAIL %s observed=%0d expected=%0d", tag, counter, e);
      end
    end
  endtask

  // One slow_clk edge, then compare the resulting count.
  task automatic step(input logic [15:0] e, input string tag);
    exp_q.push_back(e);
    @(posedge slow_clk);
    #1;
    check_now(tag);
  endtask

  task automatic steps(input int n, input logic [15:0] e, input string tag);
    for (int i = 0; i < n; i++) step(e, tag);
  endtask

  task automatic seq(input logic [15:0] first, input int n, input logic [15:0] p,
                     input string tag);
    logic [15:0] v;
    v = first;
    for (int i = 0; i < n; i++) begin
      step(v, tag);
      v = (v + 16'd1 >= p) ? 16'd0 : v + 16'd1;
    end
  endtask

`ifdef MAIN_COUNTER_WRAP_PULSE_EN
  task automatic check_wrap(input logic e, input string tag);
    n_cmp++;
    assert (wrap === e) else begin
      n_bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, wrap, e);
    end
  endtask
`endif

  initial begin
    rst        = 1'b0;
    sw_rst     = 1'b0;
    irq_rst    = 1'b0;
    counter_en = 1'b0;
    mode       = 1'b1;
    timer_mode = 1'b1;
    period_reg = 16'd4;

    #3;
    exp_q.push_back(16'd0);
    check_now("reset_hold");
    @(posedge slow_clk);
    #1;
    rst = 1'b1;
    step(16'd0, "reset_release");

    // PWM P=4
    counter_en = 1'b1;
    exp_q.push_back(16'd0);
    check_now("pwm4_start");
    seq(16'd1, 8, 16'd4, "pwm4");

    // Software reset
    sw_rst = 1'b1;
    step(16'd0, "sw_rst_pwm4");
    sw_rst = 1'b0;

    // Timer continuous P=4: one idle tick then 0..4 repeating
    mode       = 1'b0;
    timer_mode = 1'b1;
    step(16'd0, "tmr_cont_arm");
    for (int r = 0; r < 2; r++) begin
      for (int v = 1; v <= 4; v++) step(16'(v), "tmr_cont");
      step(16'd0, "tmr_cont_wrap");
    end

    // Timer one-shot P=4
    sw_rst = 1'b1;
    step(16'd0, "sw_rst_tmr");
    sw_rst     = 1'b0;
    timer_mode = 1'b0;
    step(16'd0, "os_arm");
    for (int v = 1; v <= 4; v++) step(16'(v), "os_run");
    steps(6, 16'd0, "os_done");
    irq_rst = 1'b1;
    step(16'd0, "os_irq");
    irq_rst = 1'b0;
    step(16'd0, "os_rearm");
    for (int v = 1; v <= 4; v++) step(16'(v), "os_rerun");
    steps(3, 16'd0, "os_done2");

    // PWM P=10: async reset mid-cycle at count 5
    sw_rst = 1'b1;
    step(16'd0, "sw_rst_os");
    sw_rst     = 1'b0;
    mode       = 1'b1;
    period_reg = 16'd10;
    seq(16'd1, 5, 16'd10, "pwm10_pre_rst");
    #2;
    rst = 1'b0;
    #1;
    exp_q.push_back(16'd0);
    check_now("async_rst");
    counter_en = 1'b0;
    #1;
    rst = 1'b1;
    step(16'd0, "async_rst_release");
    counter_en = 1'b1;

    // sw_rst at count 5
    seq(16'd1, 5, 16'd10, "pwm10_pre_sw");
    sw_rst = 1'b1;
    step(16'd0, "sw_rst_at5");
    sw_rst = 1'b0;

    // Pause at 5, resume to wrap
    seq(16'd1, 5, 16'd10, "pwm10_pre_pause");
    counter_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(16'd5, "pause_hold");
`ifdef MAIN_COUNTER_WRAP_PULSE_EN
      check_wrap(1'b0, "wrap_paused");
`endif
    end
    counter_en = 1'b1;
    for (int v = 6; v <= 9; v++) begin
      step(16'(v), "resume");
`ifdef MAIN_COUNTER_WRAP_PULSE_EN
      check_wrap(1'b0, "wrap_resume");
`endif
    end
    step(16'd0, "resume_wrap");
`ifdef MAIN_COUNTER_WRAP_PULSE_EN
    check_wrap(1'b1, "wrap_pulse");
`endif
    step(16'd1, "after_wrap");
`ifdef MAIN_COUNTER_WRAP_PULSE_EN
    check_wrap(1'b0, "wrap_after");
`endif

    // Lower period below current count
    seq(16'd2, 6, 16'd10, "pwm10_climb");
    period_reg = 16'd4;
    step(16'd0, "period_lowered");
    step(16'd1, "period_lowered_run");

    // Period 0 holds at 0 in both modes
    period_reg = 16'd0;
    steps(3, 16'd0, "pwm_p0");
    mode       = 1'b0;
    timer_mode = 1'b1;
    steps(3, 16'd0, "tmr_p0");

    // Mode switch mid-count: PWM 3 -> timer continues from held value
    period_reg = 16'd6;
    mode       = 1'b1;
    seq(16'd1, 3, 16'd6, "pwm6");
    mode = 1'b0;
    step(16'd3, "switch_arm");
    step(16'd4, "switch_run");
    step(16'd5, "switch_run");
    step(16'd6, "switch_run");
    step(16'd0, "switch_wrap");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
